c_writeback_ctrl: RTL and testbench

//  Write-back end of the 8x8 blocked matrix-multiply datapath; the counterpart of the A/B operand read-address generator.
//  - Accepts one 2x2 block of finished C results from the MAC array per valid/ready handshake.
//  - Serialises each block into four single-word writes to the C RAM.
//  - Block order matches the operand reader: j inner (step 2), i outer (step 2), 16 blocks total.
//  - Raises done after the 64th write.

---
 rtl/matmul_pkg.sv | 11 +
 rtl/c_writeback_ctrl_if.sv | 15 +
 rtl/c_writeback_ctrl_blk_index_ctr.sv | 29 ++
 rtl/c_writeback_ctrl.sv | 56 +++++
 tb/tb_c_writeback_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and write-back FSM encoding for the blocked 8x8 matmul datapath
package matmul_pkg;
  localparam int N          = 8;
  localparam int BLK        = 2;
  localparam int NUM_BLK    = N * N / (BLK * BLK);
  localparam int COL_STRIDE = N;
  localparam int DATA_W     = 19;
  localparam int ADDR_W     = 8;
  localparam int IDX_W      = $clog2(N);
  typedef enum logic [2:0] {IDLE, W00, W10, W01, W11, DONE} wb_state_t;
endpackage

// File: rtl/c_writeback_ctrl_if.sv
// c_writeback_ctrl_if: MAC-result handshake plus C RAM write port
interface c_writeback_ctrl_if import matmul_pkg::*; ();
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] c00;
  logic [DATA_W-1:0] c10;
  logic [DATA_W-1:0] c01;
  logic [DATA_W-1:0] c11;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              done;
  modport master (output res_valid, c00, c10, c01, c11, input res_ready, c_we, c_addr, c_wdata, done);
  modport slave  (input res_valid, c00, c10, c01, c11, output res_ready, c_we, c_addr, c_wdata, done);
endinterface

// File: rtl/c_writeback_ctrl_blk_index_ctr.sv
// blk_index_ctr: walks 2x2 block origins, j inner and i outer, flagging the final block
module blk_index_ctr import matmul_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic             j_wrap;
  always_comb begin
    j_wrap = j_q == IDX_W'(N - BLK);
    i_d    = (adv && j_wrap) ? i_q + IDX_W'(BLK) : i_q;
    j_d    = adv ? (j_wrap ? '0 : j_q + IDX_W'(BLK)) : j_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end
  assign i    = i_q;
  assign j    = j_q;
  assign last = j_wrap && i_q == IDX_W'(N - BLK);
endmodule

// File: rtl/c_writeback_ctrl.sv
// c_writeback_ctrl: serialises 2x2 C blocks into column-major single-word C RAM writes
module c_writeback_ctrl import matmul_pkg::*; (
  input logic               clk,
  input logic               reset,
  c_writeback_ctrl_if.slave bus
);
  wb_state_t                        state_q, state_d;
  logic [BLK*BLK-1:0][DATA_W-1:0]   hold_q, hold_d;
  logic                             we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic [IDX_W-1:0]                 i, j;
  logic                             adv, last, accept, writing, row_off, col_off;
  blk_index_ctr u_idx (.clk(clk), .reset(reset), .adv(adv), .i(i), .j(j), .last(last));
  assign bus.res_ready = reset && (state_q == IDLE || state_q == W11);
  // Each W state emits its own word at the following edge; row/col offsets pick buffer slot and address.
  always_comb begin
    accept  = bus.res_valid && bus.res_ready;
    writing = state_q inside {W00, W10, W01, W11};
    row_off = state_q inside {W10, W11};
    col_off = state_q inside {W01, W11};
    adv     = state_q == W11;
    hold_d  = accept ? {bus.c11, bus.c01, bus.c10, bus.c00} : hold_q;
    we_d    = writing;
    addr_d  = writing ? ADDR_W'((int'(j) + int'(col_off)) * COL_STRIDE + int'(i) + int'(row_off)) : addr_q;
    wdata_d = writing ? hold_q[{col_off, row_off}] : wdata_q;
    done_d  = done_q || state_q == DONE;
    state_d = state_q == W00 ? W10 :
              state_q == W10 ? W01 :
              state_q == W01 ? W11 :
              (state_q == W11 && last) ? DONE :
              accept ? W00 :
              state_q == W11 ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end
  assign bus.c_we    = we_q;
  assign bus.c_addr  = addr_q;
  assign bus.c_wdata = wdata_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_c_writeback_ctrl.sv
// tb_c_writeback_ctrl: randomized blocks checked against a queue of expected column-major writes
module tb_c_writeback_ctrl;
  import matmul_pkg::*;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
  logic clk, reset;
  int   checks, fails, we_cnt, blk_cnt;
  wr_t  exp_q[$];
  c_writeback_ctrl_if bus ();
  c_writeback_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic nstep();
    @(negedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus.c_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) check("spurious_we", 32'(bus.c_we), 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.c_addr), 32'(e.a));
        check("wr_data", 32'(bus.c_wdata), 32'(e.d));
      end
    end
  end
  // Reference: block k has origin i=2*(k/4), j=2*(k%4); element (r,c) lives at c*N+r.
  task automatic push_block(input logic [3:0][DATA_W-1:0] d);
    int bi, bj;
    bi = (blk_cnt / 4) * 2;
    bj = (blk_cnt % 4) * 2;
    exp_q.push_back('{ADDR_W'(bj * N + bi), d[0]});
    exp_q.push_back('{ADDR_W'(bj * N + bi + 1), d[1]});
    exp_q.push_back('{ADDR_W'((bj + 1) * N + bi), d[2]});
    exp_q.push_back('{ADDR_W'((bj + 1) * N + bi + 1), d[3]});
    blk_cnt++;
  endtask
  task automatic send_block(input logic [3:0][DATA_W-1:0] d);
    bit acc;
    acc = 1'b0;
    bus.res_valid = 1'b1;
    {bus.c11, bus.c01, bus.c10, bus.c00} = d;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = bus.res_ready;
      @(posedge clk);
      if (!acc) nstep();
    end
    if (acc) push_block(d);
    else check("accept", 32'(acc), 1);
    nstep();
  endtask
  function automatic logic [3:0][DATA_W-1:0] rnd_block();
    return {DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)};
  endfunction
  task automatic do_reset();
    reset = 1'b0;
    bus.res_valid = 1'b0;
    nstep();
    exp_q.delete();
    blk_cnt = 0;
    we_cnt = 0;
    nstep();
    check("rst_ready", 32'(bus.res_ready), 0);
    check("rst_we", 32'(bus.c_we), 0);
    check("rst_addr", 32'(bus.c_addr), 0);
    check("rst_wdata", 32'(bus.c_wdata), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    #1;
    check("rst_ready_idle", 32'(bus.res_ready), 1);
  endtask
  initial begin
    checks = 0; fails = 0; we_cnt = 0; blk_cnt = 0;
    reset = 1'b0;
    bus.res_valid = 1'b0;
    {bus.c00, bus.c10, bus.c01, bus.c11} = '0;
    do_reset();
    send_block({19'd4, 19'd3, 19'd2, 19'd1});
    bus.res_valid = 1'b0;
    check("t1_ready_w00", 32'(bus.res_ready), 0);
    check("t1_we_w00", 32'(bus.c_we), 0);
    for (int k = 1; k <= 5; k++) begin
      nstep();
      check("t1_we", 32'(bus.c_we), 32'(k < 5));
      check("t1_ready", 32'(bus.res_ready), 32'(k >= 3));
    end
    check("t1_drain", exp_q.size(), 0);
    do_reset();
    send_block({19'd4, 19'd3, 19'd2, 19'd1});
    send_block({19'd8, 19'd7, 19'd6, 19'd5});
    check("t2_we_join", 32'(bus.c_we), 1);
    bus.res_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nstep();
      check("t2_we_b", 32'(bus.c_we), 1);
    end
    nstep();
    check("t2_idle", 32'(bus.c_we), 0);
    check("t2_drain", exp_q.size(), 0);
    do_reset();
    send_block(rnd_block());
    bus.res_valid = 1'b0;
    repeat (4) nstep();
    for (int k = 0; k < 3; k++) begin
      nstep();
      check("t4_gap_we", 32'(bus.c_we), 0);
      check("t4_gap_ready", 32'(bus.res_ready), 1);
    end
    send_block(rnd_block());
    bus.res_valid = 1'b0;
    repeat (5) nstep();
    check("t4_drain", exp_q.size(), 0);
    do_reset();
    for (int b = 0; b < NUM_BLK; b++) begin
      send_block(rnd_block());
      if (b == NUM_BLK - 1) bus.res_valid = 1'b0;
      else if ($urandom_range(0, 2) == 0) begin
        bus.res_valid = 1'b0;
        repeat ($urandom_range(0, 3)) nstep();
      end
    end
    repeat (4) nstep();
    check("t3_done_pre", 32'(bus.done), 0);
    check("t3_last_we", 32'(bus.c_we), 1);
    check("t3_last_addr", 32'(bus.c_addr), 63);
    nstep();
    check("t3_done", 32'(bus.done), 1);
    check("t3_we_off", 32'(bus.c_we), 0);
    check("t3_ready_off", 32'(bus.res_ready), 0);
    check("t3_we_total", we_cnt, 64);
    bus.res_valid = 1'b1;
    {bus.c00, bus.c10, bus.c01, bus.c11} = {4{19'h7FFFF}};
    for (int k = 0; k < 6; k++) begin
      nstep();
      check("t6_we", 32'(bus.c_we), 0);
      check("t6_done", 32'(bus.done), 1);
      check("t6_ready", 32'(bus.res_ready), 0);
    end
    do_reset();
    send_block(rnd_block());
    bus.res_valid = 1'b0;
    nstep();
    reset = 1'b0;
    nstep();
    check("t5_we_abort", 32'(bus.c_we), 0);
    check("t5_done", 32'(bus.done), 0);
    check("t5_ready", 32'(bus.res_ready), 0);
    do_reset();
    send_block(rnd_block());
    bus.res_valid = 1'b0;
    repeat (5) nstep();
    check("t5_we_count", we_cnt, 4);
    check("end_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
